// File: rtl/hs_response_checker.sv
// hs_response_checker: checks half-subtractor samples against the golden function,
// counts vectors and mismatches, captures the first failure and reports pass/fail.
module hs_response_checker #(
    parameter int N_VECTORS = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [3:0]       first_err_vec,
    output logic             err_seen
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_VECTORS - 1);

    logic [1:0]       state_q, state_d;
    logic             pass_q, pass_d, seen_q, seen_d;
    logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d, idx_q, idx_d, err_inc;
    logic [3:0]       fv_q, fv_d;
    logic             take, accept, miss;

    always_comb begin
        take    = start && state_q != RUN;
        accept  = valid && state_q == RUN;
        miss    = (c != (~a & b)) || (d != (a ^ b));
        err_inc = (miss && err_q != '1) ? err_q + 1'b1 : err_q;
        state_d = state_q;
        pass_d  = pass_q;
        vec_d   = vec_q;
        err_d   = err_q;
        idx_d   = idx_q;
        fv_d    = fv_q;
        seen_d  = seen_q;
        if (take) begin
            state_d = RUN;
            pass_d  = 1'b0;
            vec_d   = '0;
            err_d   = '0;
            idx_d   = '0;
            fv_d    = '0;
            seen_d  = 1'b0;
        end else if (accept) begin
            vec_d = vec_q + 1'b1;
            err_d = err_inc;
            if (miss && !seen_q) begin
                idx_d  = vec_q;
                fv_d   = {a, b, c, d};
                seen_d = 1'b1;
            end
            // pass uses the count including this final sample
            if (vec_q == LAST) begin
                state_d = DONE;
                pass_d  = (err_inc == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            fv_q    <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            fv_q    <= fv_d;
            seen_q  <= seen_d;
        end
    end

    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign pass          = pass_q;
    assign vec_count     = vec_q;
    assign err_count     = err_q;
    assign first_err_idx = idx_q;
    assign first_err_vec = fv_q;
    assign err_seen      = seen_q;
endmodule

// File: tb/tb_hs_response_checker.sv
// tb_hs_response_checker: directed stimulus against a sample-list model of the checker,
// compared every cycle, plus literal checks pinning the model.
module tb_hs_response_checker;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, valid = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic busy, done, pass, err_seen;
    logic [W-1:0] vec_count, err_count, first_err_idx;
    logic [3:0] first_err_vec;

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;

    logic [3:0] good [4] = '{4'b0000, 4'b0111, 4'b1001, 4'b1100};

    bit m_run = 1'b0, m_done = 1'b0, m_pass = 1'b0;
    logic [3:0] m_s [$];

    hs_response_checker #(.N_VECTORS(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_vec(first_err_vec),
        .err_seen(err_seen)
    );

    always #5 clk = ~clk;

    function automatic bit bad(input logic [3:0] v);
        return (v[1] != (~v[3] & v[2])) || (v[0] != (v[3] ^ v[2]));
    endfunction

    function automatic int m_errs();
        int n = 0;
        foreach (m_s[i]) if (bad(m_s[i])) n++;
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int m_first();
        foreach (m_s[i]) if (bad(m_s[i])) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        int f;
        f = m_first();
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("vec_count", vec_count, m_s.size());
        chk("err_count", err_count, m_errs());
        chk("err_seen", err_seen, f >= 0);
        chk("first_err_idx", first_err_idx, (f >= 0) ? f : 0);
        chk("first_err_vec", first_err_vec, (f >= 0) ? m_s[f] : 4'b0000);
    end

    task automatic m_clear();
        m_run = 1'b0; m_done = 1'b0; m_pass = 1'b0;
        m_s.delete();
    endtask

    task automatic step(input logic s, input logic v, input logic [3:0] abcd);
        @(negedge clk);
        start = s; valid = v;
        {a, b, c, d} = abcd;
        @(posedge clk);
        if (!m_run && s) begin
            m_clear();
            m_run = 1'b1;
        end else if (m_run && v) begin
            m_s.push_back(abcd);
            if (m_s.size() == N) begin
                m_run = 1'b0; m_done = 1'b1; m_pass = (m_errs() == 0);
            end
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        m_clear();
        @(negedge clk);
        #1 rst = 1'b0;
        start = 1'b0; valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        rst = 1'b1;
        #12 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_vec", vec_count, 0);

        // clean run
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, good[i]);
        #1;
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_vec", vec_count, 4);
        chk("t1_err", err_count, 0);
        chk("t1_seen", err_seen, 0);
        idle(2);

        // index 2 driven with d=0
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 2) ? 4'b1000 : good[i]);
        #1;
        chk("t2_err", err_count, 1);
        chk("t2_idx", first_err_idx, 2);
        chk("t2_vec", first_err_vec, 4'b1000);
        chk("t2_pass", pass, 0);
        chk("t2_done", done, 1);

        // restart from failing DONE; mismatches at 1 and 3; start mid-run ignored
        step(1'b1, 1'b0, 4'b0000);
        #1;
        chk("t3_cleared_err", err_count, 0);
        chk("t3_cleared_seen", err_seen, 0);
        step(1'b0, 1'b1, good[0]);
        step(1'b0, 1'b1, 4'b0101);
        step(1'b1, 1'b1, good[2]);
        #1;
        chk("t3_midstart_vec", vec_count, 3);
        chk("t3_midstart_err", err_count, 1);
        step(1'b0, 1'b1, 4'b1101);
        #1;
        chk("t3_err", err_count, 2);
        chk("t3_idx", first_err_idx, 1);
        chk("t3_vec", first_err_vec, 4'b0101);

        // start+valid together in DONE: sample discarded, clean run passes
        step(1'b1, 1'b1, 4'b1111);
        #1;
        chk("t6_vec0", vec_count, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, good[i]);
        #1;
        chk("t6_pass", pass, 1);

        // valid in IDLE ignored, gapped samples
        pulse_rst();
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b1, 4'b0001);
        #1;
        chk("t4_idle_vec", vec_count, 0);
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, good[i]);
            #1;
            chk("t4_done_timing", done, i == 3);
            if (i < 3) idle(2);
        end
        chk("t4_vec", vec_count, 4);

        // reset mid-run then clean run
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, good[1]);
        pulse_rst();
        #1;
        chk("t5_rst_vec", vec_count, 0);
        chk("t5_rst_err", err_count, 0);
        chk("t5_rst_seen", err_seen, 0);
        chk("t5_rst_busy", busy, 0);
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, good[i]);
        #1;
        chk("t5_pass", pass, 1);
        chk("t5_vec", vec_count, 4);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hs_response_checker.md
# hs_response_checker

Synthesizable response checker for the half-subtractor datapath. It samples each applied operand pair together with the DUT's difference and borrow outputs, and compares them against the golden half-subtractor function. It counts vectors and mismatches, latches the first failing vector, and reports pass/fail once a programmed number of vectors has been checked. It sits on the output side of the half-subtractor, complementing the stimulus generator that drives a and b.

## Interface
- N_VECTORS, default 4: number of valid samples in one check run; legal range 1 to 2**CNT_W-1.
- CNT_W, default 8: width of all counters and indices.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- valid  in  1  marks a, b, c and d as a sample for this cycle.
- a  in  1  minuend applied to the DUT.
- b  in  1  subtrahend applied to the DUT.
- c  in  1  DUT borrow output.
- d  in  1  DUT difference output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count == 0; low otherwise.
- vec_count  out  CNT_W  number of samples accepted in the current run.
- err_count  out  CNT_W  number of mismatching samples; saturates at all-ones.
- first_err_idx  out  CNT_W  vec_count value of the first mismatching sample.
- first_err_vec  out  4  {a,b,c,d} of the first mismatching sample.
- err_seen  out  1  sticky; set by the first mismatch in a run.

## Operation
- Golden model: exp_d = a ^ b; exp_c = ~a & b. A sample mismatches if c != exp_c or d != exp_d.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 moves to RUN.
  - RUN: each valid=1 cycle accepts one sample. On the sample where vec_count == N_VECTORS-1, move to DONE.
  - DONE: outputs hold. start=1 moves to RUN.
- Every IDLE→RUN or DONE→RUN transition clears vec_count, err_count, first_err_idx, first_err_vec and err_seen in the same edge.
- valid is ignored in IDLE and DONE. start is ignored in RUN.
- start and valid high in the same cycle in IDLE or DONE: the start is taken and the valid sample is discarded.
- Per accepted sample, all in the same edge:
  - vec_count increments.
  - On a mismatch, err_count increments unless it is already all-ones.
  - On a mismatch with err_seen=0, capture first_err_idx = pre-increment vec_count, capture first_err_vec = {a,b,c,d}, and set err_seen.
- Later mismatches never overwrite the first-error capture.
- pass is a registered output. It is updated on the edge entering DONE, from the final err_count including the last sample, and cleared on leaving DONE.
- Reset, including reset asserted mid-run: the state returns to IDLE. All outputs go to 0: busy, done, pass, counters, first_err_idx, first_err_vec and err_seen. The partial run is discarded.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- A sample accepted at edge k is reflected in vec_count, err_count and the capture registers immediately after edge k.
- busy rises the edge after start is sampled.
- done and pass become valid the edge after the final sample is accepted. busy falls on that same edge.
- Back-to-back valid is supported at one sample per cycle. Gaps in valid stall the run with no penalty.
- Minimum run length is N_VECTORS+1 cycles from start to done.

## Test plan
- Correct DUT, vectors 00,01,10,11 with c/d = 0/0, 1/1, 0/1, 0/0 → done=1, pass=1, vec_count=4, err_count=0, err_seen=0.
- Same vectors, but vector index 2 (a=1,b=0) is driven with d=0 → err_count=1, first_err_idx=2, first_err_vec=4'b1000, pass=0.
- Mismatches on indices 1 and 3 → err_count=2, first_err_idx=1. The capture is not overwritten by index 3.
- valid toggling with 2-cycle gaps, plus valid pulses in IDLE before start → only the 4 in-run samples are counted. done asserts the cycle after the 4th sample.
- rst pulsed after 2 samples → all outputs 0, state IDLE. Then start plus 4 clean samples → pass=1 with vec_count=4.
- Two cases during and after runs:
  - start asserted mid-RUN → ignored, no counter clear.
  - start in DONE after a failing run → counters cleared, and a new clean run yields pass=1.
